mem_stream_reader: RTL and testbench

Read-side initiator for the 1K x 16 on-chip memory. A command (base address, length, read timing) makes the block drive the memory's read port in external-address mode. It captures each returned word and streams it to a downstream neural-engine consumer over a valid/ready interface. A small output FIFO absorbs consumer back-pressure.

---
 rtl/mem_stream_reader.sv | 151 +++++++++++++++
 tb/tb_mem_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Read-side initiator for the 1K x 16 on-chip memory: walks base..base+length-1 and streams words through a small FWFT FIFO.
// Optional MEM_STREAM_READER_CHECKSUM_EN adds an XOR checksum of every streamed word.
module mem_stream_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              multi_cycle,
    input  logic [1:0]        cycle_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_use_external_addr,
    output logic              mem_multi_cycle_mode,
    output logic [1:0]        mem_cycle_count,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [2:0]        fsm_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mc_q;
    logic [1:0]        cc_q;
    logic [1:0]        wait_q;
    logic              zero_done_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic accept, push, pop, rd_last, last_word, drain_done;

    // Handshake: a word transfers on every cycle where out_valid && out_ready; out_data is the FIFO head.
    assign accept    = (state == S_IDLE) && start;
    assign push      = (state == S_CAPTURE);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign rd_last   = (wait_q == (mc_q ? cc_q : 2'd0));
    assign last_word = ((idx_q + 1'b1) == len_q);

    always_comb begin
        state_nx   = state;
        drain_done = 1'b0;
        case (state)
            S_IDLE:    if (start && (length != '0)) state_nx = S_ISSUE;
            S_ISSUE:   if (count < FULL_CNT) state_nx = S_READ;
            S_READ:    if (rd_last) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = last_word ? S_DRAIN : S_ISSUE;
            S_DRAIN: begin
                if (pop && (count == CNT_W'(1))) begin
                    drain_done = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    assign busy                  = (state != S_IDLE);
    assign done                  = zero_done_q | drain_done;
    assign mem_rd_en             = (state == S_READ);
    assign mem_addr              = addr_q;
    assign mem_use_external_addr = 1'b1;
    assign mem_multi_cycle_mode  = mc_q;
    assign mem_cycle_count       = cc_q;
    assign fsm_state             = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            mc_q        <= 1'b0;
            cc_q        <= 2'd0;
            wait_q      <= 2'd0;
            zero_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            zero_done_q <= accept && (length == '0);
            if (accept) begin
                addr_q <= base_addr;
                len_q  <= length;
                mc_q   <= multi_cycle;
                cc_q   <= cycle_count;
                idx_q  <= '0;
            end else if (push) begin
                addr_q <= addr_q + 1'b1;
                idx_q  <= idx_q + 1'b1;
            end
            // Wait counter runs only in READ so every read starts from zero.
            if ((state == S_READ) && !rd_last) wait_q <= wait_q + 2'd1;
            else                               wait_q <= 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept) checksum <= '0;
        else if (pop)        checksum <= checksum ^ out_data;
    end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a registered multi-cycle memory model and a word scoreboard.
module tb_mem_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        multi_cycle;
    logic [1:0]  cycle_count;
    logic        busy, done, mem_rd_en;
    logic [9:0]  mem_addr;
    logic        mem_use_external_addr, mem_multi_cycle_mode;
    logic [1:0]  mem_cycle_count;
    logic [15:0] mem_data_in;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [2:0]  fsm_state;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    mem_stream_reader #(.ADDR_W(10), .DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .multi_cycle(multi_cycle), .cycle_count(cycle_count),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_use_external_addr(mem_use_external_addr),
        .mem_multi_cycle_mode(mem_multi_cycle_mode),
        .mem_cycle_count(mem_cycle_count), .mem_data_in(mem_data_in),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .fsm_state(fsm_state)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- memory model: data_out registered at the edge ending the last rd_en cycle ----
    logic [15:0] mem [0:1023];
    logic [1:0]  mcnt = 2'd0;
    logic [15:0] mem_q = 16'h0;
    assign mem_data_in = mem_q;

    always @(posedge clk) begin
        if (reset) mcnt <= 2'd0;
        else if (mem_rd_en) begin
            if (!mem_multi_cycle_mode || (mcnt == mem_cycle_count)) begin
                mem_q <= mem[mem_addr];
                mcnt  <= 2'd0;
            end else mcnt <= mcnt + 2'd1;
        end else mcnt <= 2'd0;
    end

    // ---- monitor ----
    int          cyc = 0, rd_cycles = 0, done_cnt = 0, done_cyc = -1, last_pop_cyc = -2;
    int          burst_len = 0;
    logic        prev_rd = 1'b0;
    int          bursts_q[$];
    int          rise_q[$];
    logic [9:0]  addr_q[$];
    logic [15:0] got_q[$];

    always @(negedge clk) begin
        cyc++;
        if (mem_rd_en) begin
            rd_cycles++;
            if (!prev_rd) begin
                rise_q.push_back(cyc);
                addr_q.push_back(mem_addr);
            end
            burst_len++;
        end else if (prev_rd) begin
            bursts_q.push_back(burst_len);
            burst_len = 0;
        end
        prev_rd = mem_rd_en;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            last_pop_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---- scoreboard ----
    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_words(input string tag);
        check_eq($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic clear_mon();
        rd_cycles = 0; done_cnt = 0; done_cyc = -1; last_pop_cyc = -2; burst_len = 0;
        bursts_q.delete(); rise_q.delete(); addr_q.delete(); got_q.delete(); exp_q.delete();
    endtask

    // ---- drivers ----
    task automatic start_cmd(input logic [9:0] b, input logic [10:0] l, input logic mc,
                             input logic [1:0] cc);
        @(posedge clk); #1;
        base_addr = b; length = l; multi_cycle = mc; cycle_count = cc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq($sformatf("%s_done_seen", tag), seen, 1);
    endtask

    // ---- stimulus ----
    initial begin
        int  nrise;
        bit  found;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        multi_cycle = 1'b0; cycle_count = 2'd0; out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA000 + 16'(i);
        for (int i = 0; i < 8; i++) mem[32 + i] = 16'hB000 + 16'(i);
        mem[10'h3FE] = 16'd1; mem[10'h3FF] = 16'd2; mem[0] = 16'd3; mem[1] = 16'd4;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_en", mem_rd_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_ext", mem_use_external_addr, 1);
        check_eq("rst_mc", mem_multi_cycle_mode, 0);
        check_eq("rst_cc", mem_cycle_count, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_state", fsm_state, 0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        check_eq("rst_csum", checksum, 0);
`endif
        reset = 1'b0;

        // basic single-cycle stream
        clear_mon();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
        start_cmd(10'h010, 11'd4, 1'b0, 2'd0);
        check_eq("t1_busy", busy, 1);
        wait_done("t1", 200);
        @(posedge clk); #1;
        check_words("t1");
        check_eq("t1_rd_cycles", rd_cycles, 4);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_done_at_last_pop", done_cyc, last_pop_cyc);
        check_eq("t1_busy_after", busy, 0);

        // multi-cycle reads, 3 cycles of rd_en per word
        clear_mon();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
        start_cmd(10'h010, 11'd4, 1'b1, 2'd2);
        check_eq("t2_mc_latched", mem_multi_cycle_mode, 1);
        check_eq("t2_cc_latched", mem_cycle_count, 2);
        wait_done("t2", 200);
        @(posedge clk); #1;
        check_words("t2");
        check_eq("t2_bursts", bursts_q.size(), 4);
        for (int i = 0; i < bursts_q.size(); i++)
            check_eq($sformatf("t2_burst%0d", i), bursts_q[i], 3);
        for (int i = 1; i < rise_q.size(); i++)
            check_eq($sformatf("t2_gap%0d", i), (rise_q[i] - rise_q[i-1]) >= 4, 1);

        // address wrap 0x3FF -> 0x000
        clear_mon();
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        start_cmd(10'h3FE, 11'd4, 1'b0, 2'd0);
        wait_done("t3", 200);
        @(posedge clk); #1;
        check_words("t3");
        check_eq("t3_nreads", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            check_eq("t3_a0", addr_q[0], 10'h3FE);
            check_eq("t3_a1", addr_q[1], 10'h3FF);
            check_eq("t3_a2", addr_q[2], 10'h000);
            check_eq("t3_a3", addr_q[3], 10'h001);
        end
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        check_eq("t3_csum", checksum, 16'h0004);
`endif

        // back-pressure: FIFO fills, FSM parks in ISSUE; inputs change after start
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'hB000 + 16'(i));
        start_cmd(10'h020, 11'd8, 1'b0, 2'd0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        check_eq("t4_csum_cleared", checksum, 0);
`endif
        base_addr = 10'h300; length = 11'd2; multi_cycle = 1'b1; cycle_count = 2'd3;
        repeat (40) @(posedge clk);
        #1;
        check_eq("t4_reads_held", rd_cycles, 4);
        check_eq("t4_rd_en_low", mem_rd_en, 0);
        check_eq("t4_state_issue", fsm_state, 1);
        check_eq("t4_valid", out_valid, 1);
        check_eq("t4_head", out_data, 16'hB000);
        out_ready = 1'b1;
        wait_done("t4", 300);
        @(posedge clk); #1;
        check_words("t4");
        check_eq("t4_done_cnt", done_cnt, 1);
        multi_cycle = 1'b0; cycle_count = 2'd0;

        // zero length, then start while busy is ignored
        clear_mon();
        start_cmd(10'h010, 11'd0, 1'b0, 2'd0);
        check_eq("t5_zero_done", done, 1);
        check_eq("t5_zero_busy", busy, 0);
        @(posedge clk); #1;
        check_eq("t5_zero_done_once", done, 0);
        check_eq("t5_zero_reads", rd_cycles, 0);
        clear_mon();
        for (int i = 0; i < 3; i++) exp_q.push_back(16'hA000 + 16'(i));
        start_cmd(10'h010, 11'd3, 1'b0, 2'd0);
        start_cmd(10'h100, 11'd1, 1'b0, 2'd0);
        wait_done("t5", 200);
        @(posedge clk); #1;
        check_words("t5");
        check_eq("t5_reads", rd_cycles, 3);
        check_eq("t5_done_cnt", done_cnt, 1);

        // reset during the second READ of a len=6 command
        clear_mon();
        out_ready = 1'b0;
        start_cmd(10'h010, 11'd6, 1'b1, 2'd3);
        nrise = 0; found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd_en && !prev_rd) nrise++;
            if (nrise == 2) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t6_second_read", found, 1);
        check_eq("t6_valid_before", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_rd_en", mem_rd_en, 0);
        check_eq("t6_valid", out_valid, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_done", done, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t6_no_done", done_cnt, 0);
        check_eq("t6_flushed", out_valid, 0);
        clear_mon();
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        start_cmd(10'h3FE, 11'd4, 1'b0, 2'd0);
        wait_done("t6", 200);
        @(posedge clk); #1;
        check_words("t6");
        check_eq("t6_done_cnt", done_cnt, 1);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        check_eq("t6_csum", checksum, 16'h0004);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
